// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: shared state and slice op-code enums for the bit-serial ALU sequencer
package serial_alu_ctrl_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT, ALU_MUL} alu_op_t;
endpackage

// File: rtl/serial_alu_ctrl_if.sv
// serial_alu_ctrl_if: request/result bus of the serial ALU
//   master drives start/op/a/b and observes busy/done/result/flags
//   slave (the sequencer) receives the request and drives status and result
interface serial_alu_ctrl_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             illegal_op;
    modport master (output start, op, a, b,
                    input  busy, done, result, zero, overflow, carry_out, illegal_op);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, zero, overflow, carry_out, illegal_op);
endinterface

// File: rtl/serial_alu_shreg.sv
// serial_alu_shreg: parallel-load, shift-right register with serial-in MSB
//   clk, reset : clock, asynchronous active-high reset
//   load, d    : parallel load (has priority over shift)
//   shift, sin : shift right by one, sin enters at the MSB
//   q          : register contents
module serial_alu_shreg #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {sin, q[WIDTH-1:1]};
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: sequences a 1-bit ALU slice LSB-first over WIDTH cycles for ADD/SUB/XOR/SLT
//   clk, reset        : clock, asynchronous active-high reset
//   bus (slave)       : start/op/a/b request, busy/done handshake, result and flags
//   slice_a/b/cin     : operand bits and carry-in driven into the slice
//   slice_cntrl       : slice control code (0 outside RUN)
//   slice_out/cout    : slice sum bit and carry-out, sampled at clk edges
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             reset,
    serial_alu_ctrl_if.slave bus,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_cntrl,
    input  logic             slice_out,
    input  logic             slice_cout
);
    localparam int CW = $clog2(WIDTH);
    state_t           state;
    alu_op_t          op_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, r_q, next_res, fin;
    logic             run, load, last, lt, arith, unused_bits;
    assign run      = state == S_RUN;
    assign load     = !run && bus.start && !bus.op[2];
    assign last     = run && cnt == CW'(WIDTH-1);
    assign next_res = {slice_out, r_q[WIDTH-1:1]};
    // On the MSB cycle carry holds the carry into the sign bit, so carry^cout is
    // signed overflow and sign^overflow is the true "a < b" of the subtraction.
    assign lt       = slice_out ^ carry ^ slice_cout;
    assign arith    = op_r == ALU_ADD || op_r == ALU_SUB;
    assign fin      = op_r == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} : next_res;
    assign slice_a     = run & a_q[0];
    assign slice_b     = run & b_q[0];
    assign slice_cin   = run & carry;
    assign slice_cntrl = run ? op_r : 3'd0;
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};
    serial_alu_shreg #(.WIDTH(WIDTH)) u_a (.clk(clk), .reset(reset), .load(load), .shift(run),
                                           .d(bus.a), .sin(1'b0), .q(a_q));
    serial_alu_shreg #(.WIDTH(WIDTH)) u_b (.clk(clk), .reset(reset), .load(load), .shift(run),
                                           .d(bus.b), .sin(1'b0), .q(b_q));
    serial_alu_shreg #(.WIDTH(WIDTH)) u_r (.clk(clk), .reset(reset), .load(load), .shift(run),
                                           .d('0), .sin(slice_out), .q(r_q));
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= S_IDLE;
            op_r           <= ALU_ADD;
            carry          <= 1'b0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.zero       <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.carry_out  <= 1'b0;
            bus.illegal_op <= 1'b0;
        end else if (run) begin
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
                state          <= S_DONE;
                bus.busy       <= 1'b0;
                bus.done       <= 1'b1;
                bus.result     <= fin;
                bus.zero       <= fin == '0;
                bus.overflow   <= arith & (carry ^ slice_cout);
                bus.carry_out  <= arith & slice_cout;
                bus.illegal_op <= 1'b0;
            end
        end else if (bus.start && bus.op[2]) begin
            state          <= S_DONE;
            bus.done       <= 1'b1;
            bus.illegal_op <= 1'b1;
            bus.result     <= '0;
            bus.zero       <= 1'b1;
            bus.overflow   <= 1'b0;
            bus.carry_out  <= 1'b0;
        end else if (bus.start) begin
            state    <= S_RUN;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            op_r     <= alu_op_t'(bus.op);
            // SUB/SLT add the inverted b plus one, so the +1 enters as carry-in
            carry    <= bus.op[0];
            cnt      <= '0;
        end else begin
            state    <= S_IDLE;
            bus.done <= 1'b0;
        end
endmodule
